// File: rtl/mem_align_swap.sv
// Registered load/store data aligner with optional byte-order swap.
// Sizes, offsets, sign handling and store strobes; one-cycle valid/ready pipeline with skid buffer.
module mem_align_swap #(
    parameter int XLEN    = 32,
    parameter bit SWAP_EN = 1'b1,
    localparam int NB     = XLEN / 8,
    localparam int OW     = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_dir,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic            in_swap,
    input  logic [OW-1:0]   in_offset,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [NB-1:0]   out_strb,
    output logic            out_misaligned
);

    genvar gi;

    logic            swap;
    logic [3:0]      bytes;
    logic [3:0]      off_ext;
    logic            size_bad;
    logic            off_bad;
    logic            misaligned;
    logic [NB-1:0]   keep;
    logic [OW+2:0]   shamt;

    assign swap       = in_swap & SWAP_EN;
    assign bytes      = 4'd1 << in_size;
    assign off_ext    = 4'(in_offset);
    assign size_bad   = (32'(bytes) > NB);
    assign off_bad    = |(off_ext & (bytes - 4'd1));
    assign misaligned = size_bad | off_bad;
    assign shamt      = {in_offset, 3'b000};

    // keep[i] marks the bytes that belong to the access: (1<<bytes)-1
    generate
        for (gi = 0; gi < NB; gi++) begin : g_keep
            assign keep[gi] = (32'(bytes) > gi);
        end
    endgenerate

    // ---------------- load path ----------------
    logic [XLEN-1:0] in_data_bs;
    logic [XLEN-1:0] ld_w;
    logic [XLEN-1:0] ld_s;
    logic [XLEN-1:0] ld_data;
    logic            ld_sign;
    logic            ld_fill;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_in_bswap
            assign in_data_bs[8*gi +: 8] = in_data[8*(NB-1-gi) +: 8];
        end
    endgenerate

    assign ld_w = swap ? in_data_bs : in_data;
    assign ld_s = ld_w >> shamt;

    always_comb begin
        ld_sign = ld_s[XLEN-1];
        case (in_size)
            2'd0:    ld_sign = ld_s[7];
            2'd1:    ld_sign = ld_s[15];
            2'd2:    ld_sign = ld_s[31];
            default: ld_sign = ld_s[XLEN-1];
        endcase
    end

    assign ld_fill = ~in_unsigned & ld_sign;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_ld_ext
            assign ld_data[8*gi +: 8] = keep[gi] ? ld_s[8*gi +: 8] : {8{ld_fill}};
        end
    endgenerate

    // ---------------- store path ----------------
    logic [XLEN-1:0] st_d;
    logic [XLEN-1:0] st_sh;
    logic [XLEN-1:0] st_sh_bs;
    logic [NB-1:0]   st_m;
    logic [NB-1:0]   st_m_rev;
    logic [XLEN-1:0] st_data;
    logic [NB-1:0]   st_strb;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_st_trunc
            assign st_d[8*gi +: 8] = keep[gi] ? in_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign st_sh = st_d << shamt;
    assign st_m  = keep << in_offset;

    generate
        for (gi = 0; gi < NB; gi++) begin : g_st_swap
            assign st_sh_bs[8*gi +: 8] = st_sh[8*(NB-1-gi) +: 8];
            assign st_m_rev[gi]        = st_m[NB-1-gi];
        end
    endgenerate

    assign st_data = swap ? st_sh_bs : st_sh;
    assign st_strb = swap ? st_m_rev : st_m;

    // ---------------- result mux ----------------
    logic [XLEN-1:0] res_data;
    logic [NB-1:0]   res_strb;

    always_comb begin
        res_data = '0;
        res_strb = '0;
        if (!misaligned) begin
            if (in_dir) begin
                res_data = st_data;
                res_strb = st_strb;
            end else begin
                res_data = ld_data;
            end
        end
    end

    // ---------------- pipeline: output register + skid ----------------
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [NB-1:0]   out_strb_q, out_strb_d;
    logic            out_mis_q, out_mis_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_data_q, skid_data_d;
    logic [NB-1:0]   skid_strb_q, skid_strb_d;
    logic            skid_mis_q, skid_mis_d;
    logic            accept;
    logic            drain;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    assign drain    = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_strb_d   = out_strb_q;
        out_mis_d    = out_mis_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_strb_d  = skid_strb_q;
        skid_mis_d   = skid_mis_q;
        if (drain && skid_valid_q) begin
            // in_ready is low here, so no new request competes for the slot
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_strb_d   = skid_strb_q;
            out_mis_d    = skid_mis_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            if (!out_valid_q || drain) begin
                out_valid_d = 1'b1;
                out_data_d  = res_data;
                out_strb_d  = res_strb;
                out_mis_d   = misaligned;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = res_data;
                skid_strb_d  = res_strb;
                skid_mis_d   = misaligned;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
            out_mis_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_strb_q  <= '0;
            skid_mis_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_strb_q   <= out_strb_d;
            out_mis_q    <= out_mis_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_strb_q  <= skid_strb_d;
            skid_mis_q   <= skid_mis_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_strb       = out_strb_q;
    assign out_misaligned = out_mis_q;

endmodule

// File: tb/tb_mem_align_swap.sv
// Directed bench for mem_align_swap (XLEN=32, SWAP_EN=1): load/store alignment,
// sign handling, misalignment, backpressure ordering and mid-operation reset.
module tb_mem_align_swap;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_dir;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        in_swap;
    logic [1:0]  in_offset;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_misaligned;

    int checks   = 0;
    int failures = 0;

    mem_align_swap #(.XLEN(32), .SWAP_EN(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_dir         (in_dir),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .in_swap        (in_swap),
        .in_offset      (in_offset),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_strb       (out_strb),
        .out_misaligned (out_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dir, input logic [1:0] size, input logic uns,
                         input logic sw, input logic [1:0] off, input logic [31:0] data);
        in_valid    = 1'b1;
        in_dir      = dir;
        in_size     = size;
        in_unsigned = uns;
        in_swap     = sw;
        in_offset   = off;
        in_data     = data;
    endtask

    // One request with out_ready=1; result checked one cycle after the accepting edge.
    task automatic xact(input string tag, input logic dir, input logic [1:0] size,
                        input logic uns, input logic sw, input logic [1:0] off,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input logic [3:0] exp_strb, input logic exp_mis);
        out_ready = 1'b1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        drive(dir, size, uns, sw, off, data);
        step();
        in_valid = 1'b0;
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"}, 64'(out_data), 64'(exp_data));
        chk({tag, ".strb"}, 64'(out_strb), 64'(exp_strb));
        chk({tag, ".mis"}, 64'(out_misaligned), 64'(exp_mis));
        $display("xact %s dir=%0d size=%0d off=%0d in=%h -> data=%h strb=%b mis=%0d",
                 tag, dir, size, off, data, out_data, out_strb, out_misaligned);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_dir = 1'b0; in_size = 2'd0; in_unsigned = 1'b0; in_swap = 1'b0;
        in_offset = 2'd0; in_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        chk("reset.valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.data", 64'(out_data), 64'd0);
        chk("reset.strb", 64'(out_strb), 64'd0);
        chk("reset.mis", 64'(out_misaligned), 64'd0);

        //   tag             dir  size  uns  swap off  in_data       exp_data      strb   mis
        xact("ld_b_swap",    0, 2'd0, 1, 1, 2'd1, 32'h11223344, 32'h00000022, 4'b0000, 0);
        xact("ld_h_signed",  0, 2'd1, 0, 0, 2'd2, 32'h80FF0000, 32'hFFFF80FF, 4'b0000, 0);
        xact("ld_h_unsign",  0, 2'd1, 1, 0, 2'd2, 32'h80FF0000, 32'h000080FF, 4'b0000, 0);
        xact("ld_b_signed",  0, 2'd0, 0, 0, 2'd1, 32'h00008000, 32'hFFFFFF80, 4'b0000, 0);
        xact("ld_w_swap",    0, 2'd2, 0, 1, 2'd0, 32'h11223344, 32'h44332211, 4'b0000, 0);
        xact("st_b_off3",    1, 2'd0, 0, 0, 2'd3, 32'h123456AB, 32'hAB000000, 4'b1000, 0);
        xact("st_b_swap",    1, 2'd0, 0, 1, 2'd3, 32'h123456AB, 32'h000000AB, 4'b0001, 0);
        xact("st_h_off2",    1, 2'd1, 0, 0, 2'd2, 32'hCAFEBEEF, 32'hBEEF0000, 4'b1100, 0);
        xact("st_h_swap",    1, 2'd1, 0, 1, 2'd2, 32'hCAFEBEEF, 32'h0000EFBE, 4'b0011, 0);
        xact("mis_h_off1",   0, 2'd1, 0, 0, 2'd1, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 1);
        xact("mis_w_off2",   1, 2'd2, 0, 0, 2'd2, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 1);
        xact("mis_d_xlen32", 1, 2'd3, 0, 0, 2'd0, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 1);
        step();
        chk("idle.valid", 64'(out_valid), 64'd0);

        // Backpressure: A held on out_*, B in skid, C waits.
        out_ready = 1'b0;
        drive(0, 2'd0, 1, 0, 2'd0, 32'h000000A1);
        step();
        chk("bp.A.valid", 64'(out_valid), 64'd1);
        chk("bp.A.data", 64'(out_data), 64'h000000A1);
        chk("bp.A.in_ready", 64'(in_ready), 64'd1);
        drive(0, 2'd0, 1, 0, 2'd1, 32'h0000B200);
        step();
        chk("bp.B.in_ready", 64'(in_ready), 64'd0);
        chk("bp.B.hold_data", 64'(out_data), 64'h000000A1);
        drive(0, 2'd0, 1, 0, 2'd2, 32'h00C30000);
        step();
        chk("bp.C.wait_ready", 64'(in_ready), 64'd0);
        chk("bp.C.hold_data", 64'(out_data), 64'h000000A1);
        out_ready = 1'b1;
        step();
        $display("xact bp_B data=%h in_ready=%0d", out_data, in_ready);
        chk("bp.B.valid", 64'(out_valid), 64'd1);
        chk("bp.B.data", 64'(out_data), 64'h000000B2);
        chk("bp.B.ready_back", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        $display("xact bp_C data=%h", out_data);
        chk("bp.C.valid", 64'(out_valid), 64'd1);
        chk("bp.C.data", 64'(out_data), 64'h000000C3);
        step();
        chk("bp.drained", 64'(out_valid), 64'd0);

        // Fill both slots, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        drive(0, 2'd2, 0, 0, 2'd0, 32'h11111111);
        step();
        drive(0, 2'd2, 0, 0, 2'd0, 32'h22222222);
        step();
        in_valid = 1'b0;
        chk("rst.full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        xact("post_rst_st_w", 1, 2'd2, 0, 0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
